// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - frame-rate match sequencer for the ball/paddle datapath
module game_sequencer #(
    parameter logic [9:0] H_LAST            = 10'd799,
    parameter logic [9:0] V_LAST            = 10'd599,
    parameter int         FRAMES_PER_ACTION = 2,
    parameter int         LIVES_INIT        = 3,
    parameter int         MISS_HOLD_FRAMES  = 60
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic [9:0] h_coord,
    input  logic [9:0] v_coord,
    input  logic       button_c,
    input  logic       button_l,
    input  logic       button_r,
    input  logic       ball_hit,
    input  logic       ball_miss,
    output logic       end_of_frame,
    output logic       action_tick,
    output logic       ball_reset,
    output logic       ball_launch,
    output logic       launch_dir,
    output logic       move_en,
    output logic [2:0] game_state,
    output logic [1:0] lives,
    output logic [7:0] score
);

    localparam int FC_W = (FRAMES_PER_ACTION > 1) ? $clog2(FRAMES_PER_ACTION) : 1;
    localparam int HC_W = $clog2(MISS_HOLD_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAMES_PER_ACTION - 1);
    localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(MISS_HOLD_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t          state;
    logic [FC_W-1:0] frame_cnt;
    logic [HC_W-1:0] hold_cnt;
    logic            hist_c;
    logic            hist_l;
    logic            hist_r;
    logic            hit_pend;
    logic            miss_pend;

    logic press_c;
    logic press_l;
    logic press_r;
    logic hit_now;
    logic miss_now;

    // Presses are rising levels relative to the previous frame step; events
    // landing on the step cycle itself are folded in with the pending flags.
    always_comb begin
        press_c  = button_c & ~hist_c;
        press_l  = button_l & ~hist_l;
        press_r  = button_r & ~hist_r;
        hit_now  = hit_pend  | (move_en & ball_hit);
        miss_now = miss_pend | (move_en & ball_miss);
    end

    assign game_state = state;

    // Frame strobe: one cycle after the last active pixel is presented
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            end_of_frame <= 1'b0;
        end else begin
            end_of_frame <= (h_coord == H_LAST) && (v_coord == V_LAST);
        end
    end

    // Button history sampled once per frame step
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_c <= 1'b0;
            hist_l <= 1'b0;
            hist_r <= 1'b0;
        end else if (end_of_frame) begin
            hist_c <= button_c;
            hist_l <= button_l;
            hist_r <= button_r;
        end
    end

    // Datapath events latched while moving, consumed at every frame step
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_pend  <= 1'b0;
            miss_pend <= 1'b0;
        end else if (end_of_frame) begin
            hit_pend  <= 1'b0;
            miss_pend <= 1'b0;
        end else begin
            if (move_en && ball_hit) begin
                hit_pend <= 1'b1;
            end
            if (move_en && ball_miss) begin
                miss_pend <= 1'b1;
            end
        end
    end

    // Match state machine with registered command pulses, lives and score
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lives       <= 2'd0;
            score       <= 8'd0;
            launch_dir  <= 1'b0;
            move_en     <= 1'b0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
            ball_reset  <= 1'b0;
            ball_launch <= 1'b0;
            action_tick <= 1'b0;
        end else begin
            ball_reset  <= 1'b0;
            ball_launch <= 1'b0;
            action_tick <= 1'b0;
            if (end_of_frame) begin
                case (state)
                    S_IDLE: begin
                        if (press_c) begin
                            lives      <= 2'(LIVES_INIT);
                            score      <= 8'd0;
                            ball_reset <= 1'b1;
                            state      <= S_SERVE;
                        end
                    end
                    S_SERVE: begin
                        if (press_l || press_r) begin
                            ball_launch <= 1'b1;
                            launch_dir  <= press_r;
                            frame_cnt   <= '0;
                            move_en     <= 1'b1;
                            state       <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (hit_now && (score != 8'hFF)) begin
                            score <= score + 8'd1;
                        end
                        if (miss_now) begin
                            lives    <= lives - 2'd1;
                            hold_cnt <= HOLD_INIT;
                            move_en  <= 1'b0;
                            state    <= S_MISS;
                        end else if (frame_cnt == FC_LAST) begin
                            action_tick <= 1'b1;
                            frame_cnt   <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + FC_W'(1);
                        end
                    end
                    S_MISS: begin
                        hold_cnt <= hold_cnt - HC_W'(1);
                        if (hold_cnt == HC_W'(1)) begin
                            if (lives == 2'd0) begin
                                state <= S_OVER;
                            end else begin
                                ball_reset <= 1'b1;
                                state      <= S_SERVE;
                            end
                        end
                    end
                    S_OVER: begin
                        if (press_c) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        move_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer against a frame-level model
module tb_game_sequencer;

    localparam int FPA = 2;
    localparam int LI  = 3;
    localparam int MH  = 60;
    localparam int L   = 5;

    logic       pixel_clk = 1'b0;
    logic       rst_n     = 1'b0;
    logic [9:0] h_coord   = 10'd0;
    logic [9:0] v_coord   = 10'd0;
    logic       button_c  = 1'b0;
    logic       button_l  = 1'b0;
    logic       button_r  = 1'b0;
    logic       ball_hit  = 1'b0;
    logic       ball_miss = 1'b0;
    logic       end_of_frame;
    logic       action_tick;
    logic       ball_reset;
    logic       ball_launch;
    logic       launch_dir;
    logic       move_en;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [7:0] score;

    game_sequencer #(
        .H_LAST(10'd799), .V_LAST(10'd599), .FRAMES_PER_ACTION(FPA),
        .LIVES_INIT(LI), .MISS_HOLD_FRAMES(MH)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .h_coord(h_coord), .v_coord(v_coord),
        .button_c(button_c), .button_l(button_l), .button_r(button_r),
        .ball_hit(ball_hit), .ball_miss(ball_miss), .end_of_frame(end_of_frame),
        .action_tick(action_tick), .ball_reset(ball_reset), .ball_launch(ball_launch),
        .launch_dir(launch_dir), .move_en(move_en), .game_state(game_state),
        .lives(lives), .score(score)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        int rst;
        int launch;
        int tick;
        int dir;
        int state;
        int lives;
        int score;
        int move;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Frame-level reference model
    int m_st, m_lives, m_score, m_dir, m_steps, m_hold, m_tick_last;
    bit m_hc, m_hl, m_hr;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_lives = 0; m_score = 0; m_dir = 0; m_steps = 0; m_hold = 0;
        m_tick_last = 0; m_hc = 0; m_hl = 0; m_hr = 0;
    endtask

    task automatic model_step(input bit c, input bit l, input bit r, input bit hit, input bit miss);
        exp_t e;
        bit pc, pl, pr;
        pc = c && !m_hc;
        pl = l && !m_hl;
        pr = r && !m_hr;
        m_hc = c; m_hl = l; m_hr = r;
        e.rst = 0; e.launch = 0; e.tick = 0;
        case (m_st)
            0: if (pc) begin m_lives = LI; m_score = 0; e.rst = 1; m_st = 1; end
            1: if (pl || pr) begin e.launch = 1; m_dir = pr ? 1 : 0; m_steps = 0; m_st = 2; end
            2: begin
                if (hit && m_score < 255) m_score++;
                if (miss) begin
                    m_lives--; m_hold = MH; m_st = 3;
                end else begin
                    m_steps++;
                    if (m_steps % FPA == 0) e.tick = 1;
                end
            end
            3: begin
                m_hold--;
                if (m_hold == 0) begin
                    if (m_lives == 0) m_st = 4;
                    else begin e.rst = 1; m_st = 1; end
                end
            end
            default: if (pc) m_st = 0;
        endcase
        e.dir = m_dir; e.state = m_st; e.lives = m_lives; e.score = m_score;
        e.move = (m_st == 2) ? 1 : 0;
        m_tick_last = e.tick;
        q.push_back(e);
    endtask

    task automatic rand_coords();
        if ($urandom_range(0, 1) == 1) begin
            h_coord = 10'd799; v_coord = 10'($urandom_range(0, 598));
        end else begin
            h_coord = 10'($urandom_range(0, 798)); v_coord = 10'd599;
        end
    endtask

    // One frame of L cycles: coordinate match on cycle L-2, frame step on L-1
    task automatic fr(input bit c, input bit l, input bit r,
                      input logic [L-1:0] hm, input logic [L-1:0] mm);
        bit mv;
        mv = (m_st == 2);
        for (int k = 0; k < L; k++) begin
            @(posedge pixel_clk); #1;
            button_c = c; button_l = l; button_r = r;
            ball_hit = hm[k]; ball_miss = mm[k];
            if (k == L - 2) begin h_coord = 10'd799; v_coord = 10'd599; end
            else rand_coords();
            if (k == L - 1) model_step(c, l, r, mv && (hm != '0), mv && (mm != '0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_eof"}, int'(end_of_frame), 0);
        chk({tag, "_tick"}, int'(action_tick), 0);
        chk({tag, "_reset"}, int'(ball_reset), 0);
        chk({tag, "_launch"}, int'(ball_launch), 0);
        chk({tag, "_dir"}, int'(launch_dir), 0);
        chk({tag, "_move"}, int'(move_en), 0);
        chk({tag, "_state"}, int'(game_state), 0);
        chk({tag, "_lives"}, int'(lives), 0);
        chk({tag, "_score"}, int'(score), 0);
    endtask

    // Monitor: checks every cycle; pops an expectation on the cycle after each frame step
    bit prev_match = 0;
    bit prev_eof   = 0;
    always @(negedge pixel_clk) begin
        if (!rst_n) begin
            prev_match = 0; prev_eof = 0;
            cur = '{0, 0, 0, 0, 0, 0, 0, 0};
        end else begin
            chk("end_of_frame", int'(end_of_frame), int'(prev_match));
            if (prev_eof) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    cur = q.pop_front();
                end
                chk("ball_reset", int'(ball_reset), cur.rst);
                chk("ball_launch", int'(ball_launch), cur.launch);
                chk("action_tick", int'(action_tick), cur.tick);
            end else begin
                chk("ball_reset_idle", int'(ball_reset), 0);
                chk("ball_launch_idle", int'(ball_launch), 0);
                chk("action_tick_idle", int'(action_tick), 0);
            end
            chk("launch_dir", int'(launch_dir), cur.dir);
            chk("game_state", int'(game_state), cur.state);
            chk("lives", int'(lives), cur.lives);
            chk("score", int'(score), cur.score);
            chk("move_en", int'(move_en), cur.move);
            prev_eof   = prev_match;
            prev_match = (h_coord == 10'd799) && (v_coord == 10'd599);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        button_c = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Start held through reset, then serve with both buttons
        fr(1, 0, 0, '0, '0);
        fr(0, 1, 1, '0, '0);
        repeat (6) fr(0, 0, 0, '0, '0);

        // Hits: several in one frame, then one on the step cycle
        fr(0, 0, 0, 5'b01011, '0);
        fr(0, 0, 0, 5'b10000, '0);
        repeat (3) fr(0, 0, 0, 5'($urandom), '0);

        // Misses down to game over, with a discarded hit while serving
        for (int i = 0; i < 3; i++) begin
            fr(0, 0, 0, '0, (i == 1) ? 5'b10000 : 5'b00100);
            repeat (MH) fr(0, 0, 0, 5'($urandom), 5'($urandom));
            if (i < 2) begin
                fr(0, 0, 0, 5'b00110, 5'b00001);
                fr(0, (i == 0), (i == 1), '0, '0);
                fr(0, 0, 0, '0, '0);
            end
        end
        fr(0, 0, 0, '0, '0);
        fr(1, 0, 0, '0, '0);
        fr(0, 0, 0, '0, '0);

        // Score saturation
        fr(1, 0, 0, '0, '0);
        fr(0, 0, 1, '0, '0);
        repeat (260) fr(0, 0, 0, 5'($urandom_range(1, 31)), '0);

        // Asynchronous reset while an action_tick pulse is high
        for (int i = 0; i < 4; i++) begin
            fr(0, 0, 0, '0, '0);
            if (m_tick_last != 0) break;
        end
        @(posedge pixel_clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        q.delete();
        model_reset();
        button_c = 0; button_l = 0; button_r = 0; ball_hit = 0; ball_miss = 0;
        repeat (2) @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;
        repeat (4) fr(0, 0, 0, '0, '0);

        // Randomized play
        for (int i = 0; i < 250; i++) begin
            fr(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0,
               ($urandom_range(0, 11) == 0) ? 5'($urandom_range(1, 31)) : 5'd0);
        end

        repeat (4) @(posedge pixel_clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
